cpu_mem_loader: RTL

//  Host-side initiator for the CPU's external memory ports.
//  - Streams a program into instruction memory (addr_ext/wen_ext).
//  - Holds cpu enable high for a programmed number of cycles.
//  - Reads back a window of data memory (addr_ext_2/ren_ext_2) onto an output stream.
//  - Sits between the testbench/host link and the cpu top; replaces direct bench pokes.

---
 rtl/cpu_mem_loader_if.sv | 32 +++
 rtl/cpu_mem_loader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_loader_if.sv
// Bus bundle between the loader and its host/cpu side: program stream in,
// dump stream out, and both external memory ports of the cpu.
interface cpu_mem_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;

  modport master (
    input  s_valid, s_data, m_ready, rdata_ext_2,
    output s_ready, m_valid, m_data, addr_ext, wen_ext, ren_ext, wdata_ext,
           addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );

  modport slave (
    output s_valid, s_data, m_ready, rdata_ext, rdata_ext_2,
    input  s_ready, m_valid, m_data, addr_ext, wen_ext, ren_ext, wdata_ext,
           addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );
endinterface

// File: rtl/cpu_mem_loader.sv
// Host-side sequencer: streams a program into imem, runs the cpu for a set
// number of cycles, then reads a wrapped window of dmem out on a stream.
module cpu_mem_loader #(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [9:0]       prog_len,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [9:0]       dump_base,
  input  logic [10:0]      dump_len,
  output logic             busy,
  output logic             done,
  output logic             cpu_enable,
  cpu_mem_loader_if.master bus
);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [9:0]       plen_reg, plen_next, i_reg, i_next;
  logic [CNT_W-1:0] run_reg, run_next, run_cnt_reg, run_cnt_next;
  logic [9:0]       base_reg, base_next;
  logic [10:0]      dlen_reg, dlen_next, j_reg, j_next;
  logic             s_ready_reg, s_ready_next, wen_reg, wen_next;
  logic [IW-1:0]    waddr_reg, waddr_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic             cpu_en_reg, cpu_en_next, ren2_reg, ren2_next;
  logic [DW-1:0]    raddr_reg, raddr_next;
  logic             m_valid_reg, m_valid_next;
  logic [63:0]      m_data_reg, m_data_next;
  logic             busy_reg, busy_next, done_reg, done_next;
  logic [9:0]       plen_clamped;
  logic [10:0]      dlen_clamped, wrap_sum;
  logic             in_hs, out_hs;

  // Where to go once the program is in: zero-length phases are skipped.
  function automatic state_t after_load(input logic [CNT_W-1:0] run, input logic [10:0] dlen);
    state_t s;
    if (run != '0)       s = RUN;
    else if (dlen != '0) s = DUMP_RD;
    else                 s = DONE;
    return s;
  endfunction

  assign plen_clamped = (prog_len > 10'(IMEM_DEPTH)) ? 10'(IMEM_DEPTH) : prog_len;
  assign dlen_clamped = (dump_len > 11'(DMEM_DEPTH)) ? 11'(DMEM_DEPTH) : dump_len;
  assign in_hs  = bus.s_valid && s_ready_reg;
  assign out_hs = m_valid_reg && bus.m_ready;

  always_comb begin
    state_next   = state_reg;
    plen_next    = plen_reg;
    i_next       = i_reg;
    run_next     = run_reg;
    run_cnt_next = run_cnt_reg;
    base_next    = base_reg;
    dlen_next    = dlen_reg;
    j_next       = j_reg;
    s_ready_next = s_ready_reg;
    wen_next     = 1'b0;
    waddr_next   = waddr_reg;
    wdata_next   = wdata_reg;
    m_data_next  = m_data_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          plen_next    = plen_clamped;
          run_next     = run_cycles;
          base_next    = dump_base;
          dlen_next    = dlen_clamped;
          i_next       = '0;
          j_next       = '0;
          run_cnt_next = '0;
          s_ready_next = (plen_clamped != '0);
          state_next   = (plen_clamped != '0) ? LOAD : after_load(run_cycles, dlen_clamped);
        end
      end
      LOAD: begin
        if (in_hs) begin
          wen_next   = 1'b1;
          waddr_next = i_reg[IW-1:0];
          wdata_next = bus.s_data;
          i_next     = i_reg + 1'b1;
          if (i_reg + 1'b1 == plen_reg) s_ready_next = 1'b0;
        end else if (i_reg == plen_reg) begin
          // one idle cycle after the last write keeps wen_ext and cpu_enable disjoint
          state_next = after_load(run_reg, dlen_reg);
        end
      end
      RUN: begin
        if (run_cnt_reg + 1'b1 == run_reg) state_next = (dlen_reg != '0) ? DUMP_RD : DONE;
        else                               run_cnt_next = run_cnt_reg + 1'b1;
      end
      DUMP_RD:  state_next = DUMP_CAP;
      DUMP_CAP: begin
        m_data_next = bus.rdata_ext_2;
        state_next  = DUMP_OUT;
      end
      DUMP_OUT: begin
        if (out_hs) begin
          j_next     = j_reg + 1'b1;
          state_next = (j_reg + 1'b1 == dlen_reg) ? DONE : DUMP_RD;
        end
      end
      default: state_next = IDLE;
    endcase

    wrap_sum = {1'b0, base_next} + {1'b0, j_next[9:0]};
    if (wrap_sum >= 11'(DMEM_DEPTH)) wrap_sum = wrap_sum - 11'(DMEM_DEPTH);
    raddr_next   = (state_next == DUMP_RD) ? wrap_sum[DW-1:0] : raddr_reg;
    ren2_next    = (state_next == DUMP_RD);
    cpu_en_next  = (state_next == RUN);
    m_valid_next = (state_next == DUMP_OUT);
    busy_next    = state_next inside {LOAD, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT};
    done_next    = (state_next == DONE);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg   <= IDLE;
      plen_reg    <= '0;
      i_reg       <= '0;
      run_reg     <= '0;
      run_cnt_reg <= '0;
      base_reg    <= '0;
      dlen_reg    <= '0;
      j_reg       <= '0;
      s_ready_reg <= 1'b0;
      wen_reg     <= 1'b0;
      waddr_reg   <= '0;
      wdata_reg   <= '0;
      cpu_en_reg  <= 1'b0;
      ren2_reg    <= 1'b0;
      raddr_reg   <= '0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      plen_reg    <= plen_next;
      i_reg       <= i_next;
      run_reg     <= run_next;
      run_cnt_reg <= run_cnt_next;
      base_reg    <= base_next;
      dlen_reg    <= dlen_next;
      j_reg       <= j_next;
      s_ready_reg <= s_ready_next;
      wen_reg     <= wen_next;
      waddr_reg   <= waddr_next;
      wdata_reg   <= wdata_next;
      cpu_en_reg  <= cpu_en_next;
      ren2_reg    <= ren2_next;
      raddr_reg   <= raddr_next;
      m_valid_reg <= m_valid_next;
      m_data_reg  <= m_data_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign busy            = busy_reg;
  assign done            = done_reg;
  assign cpu_enable      = cpu_en_reg;
  assign bus.s_ready     = s_ready_reg;
  assign bus.m_valid     = m_valid_reg;
  assign bus.m_data      = m_data_reg;
  assign bus.addr_ext    = {{(62-IW){1'b0}}, waddr_reg, 2'b00};
  assign bus.wen_ext     = wen_reg;
  assign bus.ren_ext     = 1'b0;
  assign bus.wdata_ext   = wdata_reg;
  assign bus.addr_ext_2  = {{(61-DW){1'b0}}, raddr_reg, 3'b000};
  assign bus.wen_ext_2   = 1'b0;
  assign bus.ren_ext_2   = ren2_reg;
  assign bus.wdata_ext_2 = '0;
endmodule
